fp16_max_seq: RTL and testbench
===============================

# fp16_max_seq

Sequencer that computes the FP16 maximum of a vector longer than one tree pass. It splits the vector into `cfg_chunks` beats of `LANES` elements and issues each beat to the 64-input FP16 max tree. It folds the per-beat tree results into a running maximum and emits one result per vector on a valid/ready output. It sits between the input vector stream and the max tree, and it is the front end of the softmax max-subtraction stage.

## Interface
- `LANES`, 64: elements per beat; must match tree width.
- `CNT_W`, 8: width of chunk counters; max vector length is `(2^CNT_W - 1) * LANES`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_chunks` in CNT_W: beats per vector. Sampled on the IDLE->RUN transition. The value 0 is treated as 1.
- `s_data` in LANES*16: input beat, lane i at bits `[i*16 +: 16]`.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted when `s_valid & s_ready`.
- `tree_x` out LANES*16: data to the tree.
- `tree_x_valid` out 1: valid to the tree.
- `tree_ready_all` in 1: all tree leaf inputs ready.
- `tree_max` in 16: tree result.
- `tree_max_valid` in 1: tree result valid.
- `tree_next_ready` out 1: ready to the tree output.
- `m_max` out 16: vector maximum.
- `m_valid` out 1: result valid.
- `m_ready` in 1: downstream accepts the result.
- `busy` out 1: high in RUN and OUT.

## Operation
- States:
  - IDLE: no transfers in either direction.
  - RUN: issue beats and collect tree results.
  - OUT: hold the result until it is taken.
- IDLE -> RUN:
  - Triggered by `s_valid=1`; no beat is accepted in that cycle.
  - On entry, latch `n = max(cfg_chunks,1)` and clear `issued`, `recvd` and `acc_valid`.
- RUN, issue side:
  - `issue_ok = (issued < n)`.
  - `tree_x = s_data` (combinational pass-through).
  - `tree_x_valid = s_valid & issue_ok`.
  - `s_ready = tree_ready_all & issue_ok`.
  - `issued` increments on `s_valid & s_ready`.
- RUN, collect side:
  - `tree_next_ready = 1`.
  - On `tree_max_valid`, `recvd` increments.
  - If `acc_valid=0`, the result is loaded into `acc`. Otherwise `acc` takes `max(acc, tree_max)`.
  - `acc_valid` is set by the first result.
- Issue and collect are independent. A beat issue and a result receipt in the same cycle both update their counters.
- RUN -> OUT: when a result handshake brings `recvd` to `n`.
  - `m_max` is registered from the final fold.
  - `m_valid=1` from the next cycle.
- OUT:
  - `m_valid` and `m_max` are held stable until `m_ready`.
  - On `m_valid & m_ready`, go to IDLE and clear `m_valid`.
  - The next vector starts no earlier than the IDLE->RUN rule allows.
- After `issued` reaches `n`, `s_ready` stays 0 until the next RUN entry. Beats of the following vector stall upstream; they are never merged into the current vector.
- Compare rule for `max(a,b)`, on sign-magnitude FP16 with inputs guaranteed non-NaN:
  - Sign bits differ: the positive operand wins.
  - Both positive: larger `[14:0]` wins.
  - Both negative: smaller `[14:0]` wins.
  - Equal ordering, including +0 vs -0: `acc` is kept.
- `recvd` never exceeds `n`. A `tree_max_valid` outside RUN is a protocol violation; `tree_next_ready=0` there, so the tree holds it.

## Timing
- Reset values: `s_ready=0`, `tree_x_valid=0`, `tree_next_ready=0`, `m_valid=0`, `m_max=16'h0000`, `busy=0`. State is IDLE and all counters and `acc` are 0.
- `tree_x` follows `s_data` in all states.
- Latency:
  - The controller counts results, not cycles, so any tree latency L is tolerated.
  - With `tree_ready_all=1` and continuous `s_valid`, beat k is issued in cycle 1+k after the IDLE->RUN trigger cycle.
  - `m_valid` rises 1 cycle after the final tree result handshake.
- Throughput: one beat per cycle in RUN, plus 1 bubble cycle per vector for IDLE->RUN and at least 1 cycle in OUT.
- Reset mid-operation: everything returns to reset values on the assertion edge, without waiting for a clock. Partial `acc` is discarded. The tree shares `rst_n`, so in-flight results are also flushed.
- `s_ready` depends combinationally on `tree_ready_all`. No combinational path exists from `m_ready` to `s_ready`.

## Test plan
- Single beat: `cfg_chunks=1`, lane 37=`16'h4B00`, others `16'h3C00` -> one `m_valid` pulse with `m_max=16'h4B00`; `busy` drops after the handshake.
- Multi-beat: `cfg_chunks=4`, per-beat maxima `16'h3C00`, `16'hC000`, `16'h5000`, `16'h4800` -> `m_max=16'h5000`. Exactly 4 `s_valid&s_ready` handshakes; a 5th queued beat is not accepted until after OUT.
- All-negative and signed zero:
  - Beat maxima `16'hBC00`, `16'hB800` -> `m_max=16'hB800`.
  - Beat maxima `16'h8000`, `16'h0000` -> `m_max=16'h8000`, since ties keep `acc`.
- Backpressure:
  - `tree_ready_all` low for 5 cycles mid-vector -> `s_ready=0` and `issued` frozen, with no lost or duplicated beat.
  - `m_ready` low for 10 cycles in OUT -> `m_valid` held and `m_max` stable.
- Config corner: `cfg_chunks=0` -> behaves as 1. `cfg_chunks` changed during RUN -> the latched count is used.
- Reset mid-vector: assert `rst_n=0` after 2 of 4 beats -> all outputs go to reset values asynchronously. A following 2-beat vector with maxima `16'h4000`, `16'h4200` -> `m_max=16'h4200`.

Source files
------------

// File: rtl/fp16_max_seq.sv
`timescale 1ns/1ps
// Streams a long FP16 vector through a LANES-wide max tree one beat at a time
// and folds the per-beat tree results into a single running maximum.
//
// state | meaning
// IDLE  | waiting for the first beat of a vector; nothing is accepted
// RUN   | issuing beats to the tree and folding its results
// OUT   | holding the vector maximum until downstream takes it
module fp16_max_seq #(
   parameter int LANES = 64,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CNT_W-1:0]      cfg_chunks,
   input  logic [LANES*16-1:0]   s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [LANES*16-1:0]   tree_x,
   output logic                  tree_x_valid,
   input  logic                  tree_ready_all,
   input  logic [15:0]           tree_max,
   input  logic                  tree_max_valid,
   output logic                  tree_next_ready,
   output logic [15:0]           m_max,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t           state;
   logic [CNT_W-1:0] n;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] recvd;
   logic [15:0]      acc;
   logic             acc_valid;
   logic [15:0]      fold;
   logic             issue_ok;
   logic             in_run;

   // Strict "b is greater than a"; +0 and -0 compare equal so the held value wins.
   function automatic logic fp16_gt(input logic [15:0] b, input logic [15:0] a);
      logic res;
      if (b[14:0] == 15'd0 && a[14:0] == 15'd0)
         res = 1'b0;
      else if (b[15] != a[15])
         res = ~b[15];
      else if (!b[15])
         res = (b[14:0] > a[14:0]);
      else
         res = (b[14:0] < a[14:0]);
      return res;
   endfunction

   assign in_run          = (state == RUN);
   assign issue_ok        = in_run && (issued < n);
   assign tree_x          = s_data;
   assign tree_x_valid    = s_valid & issue_ok;
   assign s_ready         = tree_ready_all & issue_ok;
   assign tree_next_ready = in_run;
   assign busy            = (state != IDLE);
   assign fold            = (!acc_valid || fp16_gt(tree_max, acc)) ? tree_max : acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         n         <= '0;
         issued    <= '0;
         recvd     <= '0;
         acc       <= '0;
         acc_valid <= 1'b0;
         m_max     <= '0;
         m_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  state     <= RUN;
                  n         <= (cfg_chunks == '0) ? CNT_W'(1) : cfg_chunks;
                  issued    <= '0;
                  recvd     <= '0;
                  acc_valid <= 1'b0;
               end
            end
            RUN: begin
               if (s_valid && s_ready)
                  issued <= issued + CNT_W'(1);
               if (tree_max_valid) begin
                  recvd     <= recvd + CNT_W'(1);
                  acc       <= fold;
                  acc_valid <= 1'b1;
                  if (recvd + CNT_W'(1) == n) begin
                     state   <= OUT;
                     m_max   <= fold;
                     m_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_max_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for fp16_max_seq: a latency-varying tree model, a beat source,
// and a monitor comparing each emitted maximum against an ordering-key reference.
module tb_fp16_max_seq;
   localparam int LANES = 64;
   localparam int CNT_W = 8;
   localparam int W     = LANES * 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] cfg_chunks;
   logic [W-1:0]     s_data;
   logic             s_valid;
   logic             s_ready;
   logic [W-1:0]     tree_x;
   logic             tree_x_valid;
   logic             tree_ready_all;
   logic [15:0]      tree_max;
   logic             tree_max_valid;
   logic             tree_next_ready;
   logic [15:0]      m_max;
   logic             m_valid;
   logic             m_ready;
   logic             busy;

   fp16_max_seq #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_chunks(cfg_chunks),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tree_x(tree_x), .tree_x_valid(tree_x_valid), .tree_ready_all(tree_ready_all),
      .tree_max(tree_max), .tree_max_valid(tree_max_valid), .tree_next_ready(tree_next_ready),
      .m_max(m_max), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] v; int rdy;} tr_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_q[$];
   logic [W-1:0] beat_q[$];
   tr_t         tree_q[$];
   int          cyc = 0;
   int          hs_count = 0;
   int          stall_t = 0;
   bit          rand_t = 0, rand_m = 0, rand_s = 0, hold_m = 0;
   logic [15:0] cur_exp;
   bit          cur_first;

   // Numeric ordering key: signed magnitude as a plain integer, both zeros map to 0.
   function automatic int key(input logic [15:0] x);
      return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
   endfunction

   function automatic logic [15:0] beat_max(input logic [W-1:0] b);
      logic [15:0] m;
      m = b[15:0];
      for (int i = 1; i < LANES; i++)
         if (key(b[i*16 +: 16]) > key(m)) m = b[i*16 +: 16];
      return m;
   endfunction

   function automatic logic [15:0] rand_fp16();
      logic [15:0] r;
      r = 16'($urandom);
      if (r[14:10] == 5'h1F && r[9:0] != 10'd0) r[9:0] = 10'd0;
      return r;
   endfunction

   function automatic logic [W-1:0] beat_with(input logic [15:0] m);
      logic [W-1:0] b;
      logic [15:0]  r;
      int           lane;
      lane = $urandom_range(0, LANES-1);
      for (int i = 0; i < LANES; i++) begin
         r = rand_fp16();
         b[i*16 +: 16] = (key(r) < key(m)) ? r : 16'hFC00;
      end
      b[lane*16 +: 16] = m;
      return b;
   endfunction

   function automatic logic [W-1:0] beat_rand();
      logic [W-1:0] b;
      for (int i = 0; i < LANES; i++) b[i*16 +: 16] = rand_fp16();
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_vec();
      cur_first = 1;
   endtask

   task automatic add_beat(input logic [W-1:0] b);
      logic [15:0] m;
      m = beat_max(b);
      beat_q.push_back(b);
      if (cur_first || key(m) > key(cur_exp)) cur_exp = m;
      cur_first = 0;
   endtask

   task automatic close_vec();
      exp_q.push_back(cur_exp);
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || beat_q.size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: pending results %0d beats %0d expected 0", name, exp_q.size(), beat_q.size());
         exp_q.delete();
         beat_q.delete();
      end
      @(posedge clk);
      #2;
      check({name, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_hs(input int target);
      int t;
      t = 0;
      while (hs_count < target && t < 500) begin
         @(posedge clk);
         #3;
         t++;
      end
      if (t >= 500) begin
         checks++;
         errors++;
         $display("FAIL wait_hs timeout: got %0d handshakes expected %0d", hs_count, target);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      check({tag, "_tree_x_valid"}, 32'(tree_x_valid), 32'd0);
      check({tag, "_tree_next_ready"}, 32'(tree_next_ready), 32'd0);
      check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_m_max"}, 32'(m_max), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Beat source: presents the queued beats in order.
   initial begin
      bit fire;
      s_valid = 1'b0;
      s_data  = '0;
      forever begin
         @(negedge clk);
         fire = s_valid && s_ready;
         if (fire) hs_count++;
         @(posedge clk);
         #1;
         if (fire && beat_q.size() > 0) void'(beat_q.pop_front());
         s_valid = (beat_q.size() > 0) && (!rand_s || $urandom_range(0, 3) != 0);
         if (beat_q.size() > 0) s_data = beat_q[0];
      end
   end

   // Tree model: in-order results with a random latency of 1..4 cycles.
   initial begin
      bit          tin, tout;
      logic [15:0] v;
      tr_t         t;
      tree_max_valid = 1'b0;
      tree_max       = 16'h0;
      v              = 16'h0;
      forever begin
         @(negedge clk);
         cyc++;
         tin  = tree_x_valid && tree_ready_all;
         tout = tree_max_valid && tree_next_ready;
         if (tin) v = beat_max(tree_x);
         @(posedge clk);
         #1;
         if (tout && tree_q.size() > 0) void'(tree_q.pop_front());
         if (tin) begin
            t.v   = v;
            t.rdy = cyc + $urandom_range(0, 3);
            tree_q.push_back(t);
         end
         tree_max_valid = (tree_q.size() > 0) && (tree_q[0].rdy <= cyc);
         tree_max       = tree_max_valid ? tree_q[0].v : 16'h0;
      end
   end

   // Ready drivers for the tree inputs and the result sink.
   initial begin
      tree_ready_all = 1'b1;
      m_ready        = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_t > 0) begin
            tree_ready_all = 1'b0;
            stall_t--;
         end else begin
            tree_ready_all = rand_t ? ($urandom_range(0, 2) != 0) : 1'b1;
         end
         m_ready = hold_m ? 1'b0 : (rand_m ? ($urandom_range(0, 1) == 1) : 1'b1);
      end
   end

   // Monitor: pops the scoreboard on each result handshake and checks OUT stability.
   initial begin
      logic        pv;
      logic [15:0] pmax;
      pv   = 1'b0;
      pmax = 16'h0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (pv) begin
               check("hold_valid", 32'(m_valid), 32'd1);
               check("hold_max", 32'(m_max), 32'(pmax));
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got %0h expected no result", m_max);
               end else begin
                  check("m_max", 32'(m_max), 32'(exp_q.pop_front()));
               end
            end
            pv   = m_valid && !m_ready;
            pmax = m_max;
         end else begin
            pv = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] b;
      int           base, t, h0;
      cfg_chunks = '0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single beat with one standout lane.
      cfg_chunks = 8'd1;
      for (int i = 0; i < LANES; i++) b[i*16 +: 16] = 16'h3C00;
      b[37*16 +: 16] = 16'h4B00;
      start_vec(); add_beat(b); close_vec();
      wait_done("single");

      // Four-beat vector followed by a queued vector held back during OUT.
      cfg_chunks = 8'd4;
      hold_m = 1;
      base = hs_count;
      start_vec();
      add_beat(beat_with(16'h3C00)); add_beat(beat_with(16'hC000));
      add_beat(beat_with(16'h5000)); add_beat(beat_with(16'h4800));
      close_vec();
      start_vec();
      for (int i = 0; i < 4; i++) add_beat(beat_rand());
      close_vec();
      t = 0;
      while (!m_valid && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("hs_at_out", 32'(hs_count - base), 32'd4);
      repeat (10) begin
         @(negedge clk);
         check("out_s_ready", 32'(s_ready), 32'd0);
      end
      hold_m = 0;
      wait_done("multi");

      // Negative maxima and signed-zero tie.
      cfg_chunks = 8'd2;
      start_vec(); add_beat(beat_with(16'hBC00)); add_beat(beat_with(16'hB800)); close_vec();
      start_vec(); add_beat(beat_with(16'h8000)); add_beat(beat_with(16'h0000)); close_vec();
      wait_done("negzero");

      // Tree backpressure mid-vector.
      cfg_chunks = 8'd6;
      base = hs_count;
      start_vec();
      for (int i = 0; i < 6; i++) add_beat(beat_rand());
      close_vec();
      wait_hs(base + 2);
      stall_t = 5;
      @(posedge clk);
      #3;
      h0 = hs_count;
      repeat (5) begin
         @(negedge clk);
         check("stall_s_ready", 32'(s_ready), 32'd0);
      end
      check("stall_frozen", 32'(hs_count), 32'(h0));
      wait_done("stall");

      // Zero chunks behaves as one.
      cfg_chunks = 8'd0;
      start_vec(); add_beat(beat_rand()); close_vec();
      wait_done("cfg_zero");

      // Config change during RUN does not affect the latched count.
      cfg_chunks = 8'd3;
      base = hs_count;
      start_vec();
      for (int i = 0; i < 3; i++) add_beat(beat_rand());
      close_vec();
      wait_hs(base + 1);
      cfg_chunks = 8'd7;
      wait_done("cfg_change");

      // Asynchronous reset after two of four beats.
      cfg_chunks = 8'd4;
      base = hs_count;
      start_vec();
      for (int i = 0; i < 4; i++) add_beat(beat_rand());
      wait_hs(base + 2);
      rst_n = 1'b0;
      beat_q.delete();
      tree_q.delete();
      exp_q.delete();
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cfg_chunks = 8'd2;
      start_vec(); add_beat(beat_with(16'h4000)); add_beat(beat_with(16'h4200)); close_vec();
      wait_done("after_rst");

      // Randomized batches with random handshake timing.
      rand_t = 1; rand_m = 1; rand_s = 1;
      for (int bt = 0; bt < 8; bt++) begin
         cfg_chunks = CNT_W'($urandom_range(1, 5));
         for (int v = 0; v < 5; v++) begin
            start_vec();
            for (int k = 0; k < int'(cfg_chunks); k++)
               add_beat(($urandom_range(0, 3) == 0) ? beat_with(($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000) : beat_rand());
            close_vec();
         end
         wait_done("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
